// File: rtl/multi_switch_debouncer.sv
// Push-button front end: per-channel 2-FF sync, counter debounce,
// selectable edge pulses and hold-to-auto-repeat.
module multi_switch_debouncer #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] switch,
  input  logic [1:0]      edge_mode,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] event_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_event
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [N_CH-1:0]  meta_q;
  logic [N_CH-1:0]  sync_q;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  event_q, event_d;
  logic [N_CH-1:0]  rpt_q, rpt_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] deb_cnt_q [N_CH];
  logic [CNT_W-1:0] deb_cnt_d [N_CH];
  logic [CNT_W-1:0] rpt_cnt_q [N_CH];
  logic [CNT_W-1:0] rpt_cnt_d [N_CH];
  rpt_state_e       state_q   [N_CH];
  rpt_state_e       state_d   [N_CH];
  logic             rise_ok, fall_ok;

  assign rise_ok = (edge_mode == 2'b00) || (edge_mode == 2'b10);
  assign fall_ok = (edge_mode == 2'b01) || (edge_mode == 2'b10);

  always_comb begin
    level_d = level_q;
    event_d = '0;
    rpt_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      state_d[i]   = state_q[i];

      if (sync_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        level_d[i]   = sync_q[i];
        deb_cnt_d[i] = '0;
        event_d[i]   = sync_q[i] ? rise_ok : fall_ok;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end

      // Release or disable wins over a terminal count in the same cycle.
      if (!level_q[i] || !repeat_en[i]) begin
        state_d[i]   = IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i]   = HOLD;
            rpt_cnt_d[i] = '0;
          end
          HOLD: begin
            if (rpt_cnt_q[i] == HOLD_LAST) begin
              rpt_d[i]     = 1'b1;
              rpt_cnt_d[i] = '0;
              state_d[i]   = REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt_q[i] == RPT_LAST) begin
              rpt_d[i]     = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i]   = IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
    any_d = |(event_d | rpt_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= '0;
      sync_q  <= '0;
      level_q <= '0;
      event_q <= '0;
      rpt_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
        rpt_cnt_q[i] <= '0;
        state_q[i]   <= IDLE;
      end
    end else begin
      meta_q  <= switch;
      sync_q  <= meta_q;
      level_q <= level_d;
      event_q <= event_d;
      rpt_q   <= rpt_d;
      any_q   <= any_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign level_out    = level_q;
  assign event_pulse  = event_q;
  assign repeat_pulse = rpt_q;
  assign any_event    = any_q;

endmodule
